// File: rtl/sd_cmd_sequencer_if.sv
// SPI byte-engine link used by the SD command sequencer: byte handshake plus
// the card chip select, which travels with the engine wiring on the board.
interface sd_cmd_sequencer_if;
  logic       o_sd_cs;
  logic       o_spi_start;
  logic [7:0] o_spi_tx_data;
  logic       i_spi_done;
  logic [7:0] i_spi_rx_data;

  modport master (
    output o_sd_cs,
    output o_spi_start,
    output o_spi_tx_data,
    input  i_spi_done,
    input  i_spi_rx_data
  );

  modport slave (
    input  o_sd_cs,
    input  o_spi_start,
    input  o_spi_tx_data,
    output i_spi_done,
    output i_spi_rx_data
  );
endinterface

// File: rtl/sd_cmd_sequencer.sv
// SD-card SPI-mode command sequencer: frames CMD + argument + CRC7, polls for
// R1, optionally collects a 4-byte R3/R7 tail, then releases chip select.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a command request, chip select high
// PRE    | one FF byte of chip-select setup gap
// CMD    | six command frame bytes (index, argument, CRC7)
// POLL   | FF bytes until R1 arrives (bit 7 low) or NCR_MAX expires
// EXT    | four FF bytes collecting the R3/R7 extension
// POST   | chip select high, one trailing FF byte, then done
module sd_cmd_sequencer #(
  parameter int NCR_MAX = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_cmd_start,
  input  logic [5:0]  i_cmd_index,
  input  logic [31:0] i_cmd_arg,
  input  logic        i_resp_long,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_timeout,
  output logic [7:0]  o_r1,
  output logic [31:0] o_resp_data,
  sd_cmd_sequencer_if.master spi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_CMD,
    S_POLL,
    S_EXT,
    S_POST
  } state_t;

  state_t      state;
  logic [5:0]  idx_q;
  logic [31:0] arg_sh;
  logic        long_q;
  logic [6:0]  crc_q;
  logic [7:0]  cnt;
  logic        byte_done;

  // One MSB-first byte through the x^7+x^3+1 CRC register.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc_in, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // A byte is outstanding in every non-idle state once its start pulse has gone out.
  assign byte_done = spi.i_spi_done && !spi.o_spi_start && (state != S_IDLE);

  // Transaction sequencing; every output is registered here.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state             <= S_IDLE;
      idx_q             <= '0;
      arg_sh            <= '0;
      long_q            <= 1'b0;
      crc_q             <= '0;
      cnt               <= '0;
      o_busy            <= 1'b0;
      o_done            <= 1'b0;
      o_timeout         <= 1'b0;
      o_r1              <= 8'hFF;
      o_resp_data       <= '0;
      spi.o_sd_cs       <= 1'b1;
      spi.o_spi_start   <= 1'b0;
      spi.o_spi_tx_data <= 8'hFF;
    end else begin
      o_done          <= 1'b0;
      spi.o_spi_start <= 1'b0;
      case (state)
        S_IDLE: begin
          // A request landing in the done cycle is dropped; accept from the next one.
          if (i_cmd_start && !o_done) begin
            idx_q             <= i_cmd_index;
            arg_sh            <= i_cmd_arg;
            long_q            <= i_resp_long;
            o_busy            <= 1'b1;
            o_timeout         <= 1'b0;
            spi.o_sd_cs       <= 1'b0;
            spi.o_spi_start   <= 1'b1;
            spi.o_spi_tx_data <= 8'hFF;
            state             <= S_PRE;
          end
        end
        S_PRE: begin
          if (byte_done) begin
            crc_q             <= crc7_step(7'd0, {2'b01, idx_q});
            cnt               <= 8'd5;
            spi.o_spi_start   <= 1'b1;
            spi.o_spi_tx_data <= {2'b01, idx_q};
            state             <= S_CMD;
          end
        end
        S_CMD: begin
          // cnt counts frame bytes still to load after the one in flight.
          if (byte_done) begin
            spi.o_spi_start <= 1'b1;
            if (cnt == 8'd0) begin
              cnt               <= 8'(NCR_MAX);
              spi.o_spi_tx_data <= 8'hFF;
              state             <= S_POLL;
            end else if (cnt == 8'd1) begin
              cnt               <= cnt - 8'd1;
              spi.o_spi_tx_data <= {crc_q, 1'b1};
            end else begin
              cnt               <= cnt - 8'd1;
              crc_q             <= crc7_step(crc_q, arg_sh[31:24]);
              spi.o_spi_tx_data <= arg_sh[31:24];
              arg_sh            <= {arg_sh[23:0], 8'h00};
            end
          end
        end
        S_POLL: begin
          if (byte_done) begin
            spi.o_spi_start   <= 1'b1;
            spi.o_spi_tx_data <= 8'hFF;
            if (!spi.i_spi_rx_data[7]) begin
              o_r1 <= spi.i_spi_rx_data;
              if (long_q) begin
                cnt   <= 8'd3;
                state <= S_EXT;
              end else begin
                spi.o_sd_cs <= 1'b1;
                state       <= S_POST;
              end
            end else if (cnt == 8'd1) begin
              o_timeout   <= 1'b1;
              o_r1        <= 8'hFF;
              spi.o_sd_cs <= 1'b1;
              state       <= S_POST;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        S_EXT: begin
          if (byte_done) begin
            o_resp_data       <= {o_resp_data[23:0], spi.i_spi_rx_data};
            spi.o_spi_start   <= 1'b1;
            spi.o_spi_tx_data <= 8'hFF;
            if (cnt == 8'd0) begin
              spi.o_sd_cs <= 1'b1;
              state       <= S_POST;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
        end
        S_POST: begin
          if (byte_done) begin
            o_busy <= 1'b0;
            o_done <= 1'b1;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Bench for sd_cmd_sequencer: random-latency SPI engine, transaction-level
// reference model (frame bytes, R1 / extension / timeout outcome) and
// per-cycle handshake checks.
module tb_sd_cmd_sequencer;
  localparam int NCR = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_start;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_long;
  logic        busy, done, timeout;
  logic [7:0]  r1;
  logic [31:0] resp;

  sd_cmd_sequencer_if spi_if ();

  sd_cmd_sequencer #(.NCR_MAX(NCR)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_cmd_start (cmd_start),
    .i_cmd_index (cmd_index),
    .i_cmd_arg   (cmd_arg),
    .i_resp_long (resp_long),
    .o_busy      (busy),
    .o_done      (done),
    .o_timeout   (timeout),
    .o_r1        (r1),
    .o_resp_data (resp),
    .spi         (spi_if)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  int          done_cnt = 0;
  logic [7:0]  script[$];
  logic [7:0]  tx_log[$];
  logic [7:0]  exp_tx[$];
  logic [7:0]  m_r1 = 8'hFF;
  logic [31:0] m_resp = 32'h0;
  logic        m_to = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // CRC7 as the remainder of msg * x^7 divided by x^7+x^3+1 (long division).
  function automatic logic [6:0] model_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  // Expected byte stream and outcome of one transaction from the rx script.
  task automatic build_model(input logic [5:0] idx, input logic [31:0] arg, input logic lng);
    logic [7:0] b;
    int         k;
    logic       found;
    exp_tx.delete();
    exp_tx.push_back(8'hFF);
    exp_tx.push_back({2'b01, idx});
    for (int j = 3; j >= 0; j--) exp_tx.push_back(arg[8*j +: 8]);
    exp_tx.push_back({model_crc7({2'b01, idx, arg}), 1'b1});
    found = 1'b0;
    k = 0;
    for (int p = 0; p < NCR; p++) begin
      b = (p < script.size()) ? script[p] : 8'hFF;
      exp_tx.push_back(8'hFF);
      k = p;
      if (!b[7]) begin
        found = 1'b1;
        break;
      end
    end
    if (found) begin
      m_r1 = (k < script.size()) ? script[k] : 8'hFF;
      m_to = 1'b0;
      if (lng)
        for (int j = 0; j < 4; j++) begin
          exp_tx.push_back(8'hFF);
          b = (k + 1 + j < script.size()) ? script[k + 1 + j] : 8'hFF;
          m_resp = {m_resp[23:0], b};
        end
    end else begin
      m_r1 = 8'hFF;
      m_to = 1'b1;
    end
    exp_tx.push_back(8'hFF);
  endtask

  // SPI engine with random latency plus per-cycle handshake checks.
  initial begin : engine
    logic       outst, done_prev, rst_prev;
    logic [7:0] pend_rx;
    int         lat, bidx;
    outst = 1'b0; done_prev = 1'b0; rst_prev = 1'b1; lat = 0; pend_rx = 8'hFF;
    spi_if.i_spi_done    = 1'b0;
    spi_if.i_spi_rx_data = 8'hFF;
    forever begin
      @(negedge clk);
      if (!rst && !rst_prev) begin
        if (done_prev) begin
          chk("start_after_done", spi_if.o_spi_start, busy);
          chk("done_at_last_byte", done, !busy);
        end
        if (spi_if.o_spi_start) chk("no_overlap_start", outst, 1'b0);
        if (busy) chk("cs_low_or_post", spi_if.o_sd_cs == 1'b0 || outst || spi_if.o_spi_start, 1'b1);
      end
      if (done) done_cnt++;
      rst_prev = rst;
      done_prev = 1'b0;
      spi_if.i_spi_done = 1'b0;
      if (rst) begin
        outst = 1'b0;
      end else begin
        if (outst) begin
          if (lat == 0) begin
            spi_if.i_spi_done    = 1'b1;
            spi_if.i_spi_rx_data = pend_rx;
            outst = 1'b0;
            done_prev = 1'b1;
          end else begin
            lat--;
          end
        end
        if (spi_if.o_spi_start) begin
          bidx = tx_log.size();
          tx_log.push_back(spi_if.o_spi_tx_data);
          if (bidx < 7) pend_rx = 8'($urandom);
          else pend_rx = (bidx - 7 < script.size()) ? script[bidx - 7] : 8'hFF;
          outst = 1'b1;
          lat = $urandom_range(0, 3);
        end
      end
    end
  end

  task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic lng,
                         input int inject_at, input logic start_in_done);
    logic got;
    int   bad;
    build_model(idx, arg, lng);
    @(negedge clk);
    tx_log.delete();
    done_cnt = 0;
    cmd_start = 1'b1; cmd_index = idx; cmd_arg = arg; resp_long = lng;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("accept_busy", busy, 1'b1);
    chk("accept_cs", spi_if.o_sd_cs, 1'b0);
    chk("accept_timeout_clr", timeout, 1'b0);
    chk("accept_first_start", spi_if.o_spi_start, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (c == inject_at) begin
        cmd_start = 1'b1; cmd_index = ~idx; cmd_arg = ~arg; resp_long = ~lng;
      end else begin
        cmd_start = 1'b0;
      end
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    cmd_start = 1'b0;
    chk("done_seen", got, 1'b1);
    if (!got) return;
    chk("end_busy", busy, 1'b0);
    chk("end_cs", spi_if.o_sd_cs, 1'b1);
    chk("end_r1", r1, m_r1);
    chk("end_resp", resp, m_resp);
    chk("end_timeout", timeout, m_to);
    chk("tx_len", tx_log.size(), exp_tx.size());
    bad = -1;
    if (tx_log.size() == exp_tx.size())
      for (int i = 0; i < exp_tx.size(); i++)
        if (tx_log[i] !== exp_tx[i] && bad < 0) bad = i;
    chk("tx_first_bad_byte_idx", bad, -1);
    if (start_in_done) begin
      cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      chk("start_in_done_ignored", busy, 1'b0);
    end
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, 1);
    chk("idle_cs", spi_if.o_sd_cs, 1'b1);
  endtask

  initial begin : main
    logic ok;
    int   n, k;
    rst = 1'b1; cmd_start = 1'b0; cmd_index = '0; cmd_arg = '0; resp_long = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_r1", r1, 8'hFF);
    chk("rst_resp", resp, 32'h0);
    chk("rst_cs", spi_if.o_sd_cs, 1'b1);
    chk("rst_spi_start", spi_if.o_spi_start, 1'b0);
    chk("rst_tx_data", spi_if.o_spi_tx_data, 8'hFF);
    @(posedge clk); #2 rst = 1'b0;

    chk("model_crc_cmd0", model_crc7(40'h40_0000_0000), 7'h4A);
    chk("model_crc_cmd8", model_crc7(40'h48_0000_01AA), 7'h43);

    // CMD0, R1 on first poll
    script = {8'h01};
    run_txn(6'd0, 32'h0, 1'b0, -1, 1'b0);
    chk("lit_cmd0_len", tx_log.size(), 9);
    if (tx_log.size() == 9) chk("lit_cmd0_crc", tx_log[6], 8'h95);
    chk("lit_cmd0_r1", r1, 8'h01);

    // CMD8 long response
    script = {8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    run_txn(6'd8, 32'h0000_01AA, 1'b1, -1, 1'b1);
    if (tx_log.size() > 6) chk("lit_cmd8_crc", tx_log[6], 8'h87);
    chk("lit_cmd8_resp", resp, 32'h0000_01AA);

    // timeout: all FF, extension requested but must be skipped
    script = {};
    run_txn(6'd0, 32'h0, 1'b1, -1, 1'b0);
    chk("lit_to_len", tx_log.size(), 16);
    chk("lit_to_flag", timeout, 1'b1);
    chk("lit_to_resp_kept", resp, 32'h0000_01AA);

    // R1 on third poll, request pulsed mid-frame
    script = {8'hFF, 8'hFF, 8'h05};
    run_txn(6'd55, 32'hDEAD_BEEF, 1'b0, 8, 1'b0);
    chk("lit_poll3_len", tx_log.size(), 11);
    chk("lit_poll3_r1", r1, 8'h05);
    chk("lit_poll3_timeout", timeout, 1'b0);

    // reset during the extension phase
    script = {8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
    @(negedge clk);
    tx_log.delete();
    cmd_start = 1'b1; cmd_index = 6'd8; cmd_arg = 32'h0000_01AA; resp_long = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      if (tx_log.size() >= 9) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reached_ext", ok, 1'b1);
    #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cs", spi_if.o_sd_cs, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_r1", r1, 8'hFF);
    chk("mid_rst_resp", resp, 32'h0);
    m_r1 = 8'hFF; m_resp = 32'h0;
    n = tx_log.size();
    done_cnt = 0;
    repeat (5) @(negedge clk);
    chk("mid_rst_no_done", done_cnt, 0);
    chk("mid_rst_no_bytes", tx_log.size(), n);
    script = {8'hFF, 8'h00};
    run_txn(6'd17, 32'h0000_0200, 1'b0, -1, 1'b0);

    // randomized transactions
    for (int t = 0; t < 24; t++) begin
      script.delete();
      k = $urandom_range(0, 10);
      for (int j = 0; j < k; j++) script.push_back(8'h80 | 8'($urandom));
      script.push_back(8'($urandom) & 8'h7F);
      for (int j = 0; j < 4; j++) script.push_back(8'($urandom));
      run_txn(6'($urandom), $urandom, 1'($urandom), ($urandom_range(0, 3) == 0) ? 8 : -1,
              1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
